circuit_7458_arbiter: RTL

//  Shares one 7458-style AND-OR evaluator among NUM_REQ requesters:
//  p1y=(a&b&c)|(d&e&f), p2y=(a&b)|(c&d).

---
 rtl/gate7458_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/circuit_7458_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/gate7458_pkg.sv
// rtl/gate7458_pkg.sv - shared state encoding, operand widths and 7458 AND-OR functions
package gate7458_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int P1_W = 6;
    localparam int P2_W = 4;

    // Operand slice is {f,e,d,c,b,a}, so a sits in bit 0
    function automatic logic f_p1y(input logic [P1_W-1:0] p);
        return (p[0] & p[1] & p[2]) | (p[3] & p[4] & p[5]);
    endfunction

    // Operand slice is {d,c,b,a}
    function automatic logic f_p2y(input logic [P2_W-1:0] p);
        return (p[0] & p[1]) | (p[2] & p[3]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant starting one past the previous winner
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Offsets 1..NUM_REQ visit every requester once, ending on last_grant itself
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_id      = idx;
            end
        end
    end

endmodule

// File: rtl/circuit_7458_arbiter.sv
// rtl/circuit_7458_arbiter.sv - shares one 7458 AND-OR evaluator among round-robin requesters
module circuit_7458_arbiter
    import gate7458_pkg::*;
#(
    parameter int   NUM_REQ = 4,
    localparam int  ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [P1_W*NUM_REQ-1:0]   req_p1,
    input  logic [P2_W*NUM_REQ-1:0]   req_p2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_p1y,
    output logic                      rsp_p2y,
    output logic                      busy
);

    state_t            state, state_nx;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic              accept_en;
    logic              accept;
    logic [P1_W-1:0]   sel_p1, p1_q;
    logic [P2_W-1:0]   sel_p2, p2_q;
    logic [ID_W-1:0]   id_q;

    // A new request may enter while idle or in the same cycle the result leaves
    assign accept_en = (state == IDLE) || ((state == RESP) && rsp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .en         (accept_en),
        .last_grant (last_grant),
        .grant_oh   (grant_oh),
        .grant_id   (grant_id)
    );

    assign req_ready = grant_oh;
    assign accept    = |grant_oh;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        sel_p1 = '0;
        sel_p2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_p1 = sel_p1 | req_p1[i*P1_W +: P1_W];
                sel_p2 = sel_p2 | req_p2[i*P2_W +: P2_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EVAL;
            EVAL:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = accept ? EVAL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            p1_q       <= '0;
            p2_q       <= '0;
            id_q       <= '0;
            rsp_id     <= '0;
            rsp_p1y    <= 1'b0;
            rsp_p2y    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= grant_id;
                p1_q       <= sel_p1;
                p2_q       <= sel_p2;
                id_q       <= grant_id;
            end
            // Results only change on the way into RESP, so they hold under back-pressure
            if (state == EVAL) begin
                rsp_p1y <= f_p1y(p1_q);
                rsp_p2y <= f_p2y(p2_q);
                rsp_id  <= id_q;
            end
        end
    end

endmodule
